bpu_btb: RTL and testbench
==========================

Name: bpu_btb

Overview:
- Parametrised second-generation branch prediction unit with a direct-mapped branch target buffer (BTB) and per-entry saturating direction counters.
- Predicts taken/target for the fetch PC in the same cycle.
- Resolves branches at execute, detects mispredictions, issues flush and redirect, and trains the tables.
- Sits between the fetch PC mux and the execute-stage branch comparator; it also keeps saturating performance counters.

Parameters:
- WIDTH, 32, data/address width.
- ENTRIES, 16, number of BTB entries; power of two, at least 2.
- CTR_BITS, 2, width of each direction counter; at least 1.
- STAT_BITS, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- pc_f  in  WIDTH  current fetch PC.
- ex_valid  in  1  a conditional branch/jump resolves in execute this cycle.
- ex_pc  in  WIDTH  PC of the resolving branch.
- ex_target  in  WIDTH  computed branch target (pc+imm).
- ex_taken  in  1  actual outcome.
- ex_pred_taken  in  1  prediction carried down the pipe with this branch.
- ex_pred_target  in  WIDTH  predicted target carried down the pipe.
- stat_clr  in  1  synchronous clear of the stat counters.
- pc_next  out  WIDTH  next fetch PC.
- pred_taken_f  out  1  prediction for pc_f; pipelined by the core.
- pred_target_f  out  WIDTH  predicted target for pc_f.
- flush  out  1  misprediction; kill the fetch/decode stages.
- stat_branches  out  STAT_BITS  resolved branch count.
- stat_mispredicts  out  STAT_BITS  misprediction count.

Behaviour:
- Index width IDX = $clog2(ENTRIES).
  - index = pc[IDX+1:2].
  - tag = pc[WIDTH-1:IDX+2].
- Each entry holds: valid, tag, target[WIDTH], ctr[CTR_BITS].
- Lookup (combinational from registered table):
  - hit = valid && tag match.
  - pred_taken_f = hit && ctr MSB.
  - pred_target_f = entry target on hit, else pc_f+4.
- Mispredict (combinational): flush = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- pc_next priority:
  1. flush: ex_taken ? ex_target : ex_pc+4.
  2. else pred_taken_f: pred_target_f.
  3. else pc_f+4.
  - All additions wrap modulo 2^WIDTH.
- Update, registered on the rising clk edge when ex_valid=1, using the ex_pc index:
  - Hit, taken: ctr saturating-increments (max 2^CTR_BITS-1); target <= ex_target.
  - Hit, not taken: ctr saturating-decrements (min 0); target unchanged.
  - Miss, taken: allocate/replace. valid=1, tag, target=ex_target, ctr=2^(CTR_BITS-1) (weakly taken).
  - Miss, not taken: no change.
- Latency: an update is visible to lookup in the cycle after the update edge.
- Same-cycle read and write to the same index: the lookup sees the old entry. There is no bypass.
- Stats, on each clk edge:
  - stat_clr=1: both counters go to 0. stat_clr has priority over counting.
  - else ex_valid increments stat_branches.
  - flush increments stat_mispredicts.
  - Both saturate at all-ones and never wrap.
- Reset (rst=0, asynchronous):
  - All valid=0; all ctr=2^(CTR_BITS-1)-1 (weakly not-taken).
  - targets and tags are don't-care.
  - stats=0.
  - Outputs during and immediately after reset: pred_taken_f=0, pred_target_f=pc_f+4, pc_next=pc_f+4 unless flush.
- Reset asserted mid-update: the update is lost and all state is cleared.
- flush and pred_taken_f both high: flush wins. The prediction for pc_f is discarded.
- CTR_BITS=1: counter is a last-outcome bit. Allocation sets it to 1; reset sets it to 0.

Decomposition:
- Package bpu_pkg holds:
  - the btb_entry_t struct typedef (valid, tag, target, ctr), parametrised by localparams derived from WIDTH/ENTRIES/CTR_BITS;
  - the sat_inc/sat_dec functions;
  - the PC_STEP=4 constant.
- One sub-module, bpu_sat_ctr: a STAT_BITS-wide saturating event counter with synchronous clear. It is instantiated twice for the stats.
- The table array stays in bpu_btb.

Test Plan:
- Reset then pc_f=0x100 -> pred_taken_f=0, pc_next=0x104, flush=0, stats=0.
- Branch at 0x100 resolves taken to 0x200 with ex_pred_taken=0 -> flush=1, pc_next=0x200, stat_mispredicts=1. Next cycle pc_f=0x100 -> pred_taken_f=1, pc_next=0x200.
- Repeat the taken branch 3 times (ctr 2->3, saturating), then not-taken once -> ctr=2 and still predicts taken. A second not-taken -> ctr=1 and predicts not-taken with pc_next=0x104.
- Alias: ENTRIES=16, taken branch at 0x100 then taken branch at 0x140 (same index, different tag) -> 0x140 replaces the entry. pc_f=0x100 then misses with pc_next=0x104.
- Correct prediction with wrong target (ex_pred_target=0x200, ex_target=0x300, both taken) -> flush=1, pc_next=0x300, table target updated to 0x300.
- Preload stat_branches near all-ones (STAT_BITS=4 build, 15 events), one more ex_valid -> stays 15. Then stat_clr=1 together with ex_valid -> 0. Finally assert rst mid-stream -> valid bits cleared and the next lookup misses.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types, constants and helpers for the branch prediction unit.
package bpu_pkg;

   // Table geometry; the BTB entry layout below is built from these.
   localparam int unsigned BTB_WIDTH    = 32;
   localparam int unsigned BTB_ENTRIES  = 16;
   localparam int unsigned BTB_CTR_BITS = 2;
   localparam int unsigned BTB_IDX      = $clog2(BTB_ENTRIES);
   localparam int unsigned BTB_TAG_W    = BTB_WIDTH - BTB_IDX - 2;

   // Byte distance between sequential instructions.
   localparam int unsigned PC_STEP = 4;

   typedef struct packed {
      logic                    valid;
      logic [BTB_TAG_W-1:0]    tag;
      logic [BTB_WIDTH-1:0]    target;
      logic [BTB_CTR_BITS-1:0] ctr;
   } btb_entry_t;

   // Saturating step helpers, width-agnostic via an explicit bound.
   function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
      return (v >= max_v) ? max_v : v + 1;
   endfunction

   function automatic int unsigned sat_dec(input int unsigned v);
      return (v == 0) ? 0 : v - 1;
   endfunction

endpackage

// File: rtl/bpu_sat_ctr.sv
// Saturating event counter with synchronous clear; clear wins over counting.
module bpu_sat_ctr #(
   parameter int unsigned STAT_BITS = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_i,
   input  logic                 inc_i,
   output logic [STAT_BITS-1:0] cnt_o
);

   logic [STAT_BITS-1:0] cnt_q, cnt_d;

   // Next count: clear, else increment unless already all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + STAT_BITS'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/bpu_btb.sv
// Branch prediction unit: direct-mapped BTB with per-entry saturating direction
// counters, same-cycle lookup, execute-stage resolution/redirect and stats.
module bpu_btb
   import bpu_pkg::*;
#(
   parameter int unsigned WIDTH     = BTB_WIDTH,
   parameter int unsigned ENTRIES   = BTB_ENTRIES,
   parameter int unsigned CTR_BITS  = BTB_CTR_BITS,
   parameter int unsigned STAT_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     pc_f,
   input  logic                 ex_valid,
   input  logic [WIDTH-1:0]     ex_pc,
   input  logic [WIDTH-1:0]     ex_target,
   input  logic                 ex_taken,
   input  logic                 ex_pred_taken,
   input  logic [WIDTH-1:0]     ex_pred_target,
   input  logic                 stat_clr,
   output logic [WIDTH-1:0]     pc_next,
   output logic                 pred_taken_f,
   output logic [WIDTH-1:0]     pred_target_f,
   output logic                 flush,
   output logic [STAT_BITS-1:0] stat_branches,
   output logic [STAT_BITS-1:0] stat_mispredicts
);

   localparam int unsigned IDX     = $clog2(ENTRIES);
   localparam int unsigned CTR_MAX = (32'd1 << CTR_BITS) - 32'd1;
   // Reset leaves counters weakly not-taken; allocation starts weakly taken.
   localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);
   localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(32'd1 << (CTR_BITS - 1));
   localparam logic [WIDTH-1:0]    STEP      = WIDTH'(PC_STEP);

   btb_entry_t table_q [ENTRIES];

   logic [IDX-1:0] f_idx, ex_idx;
   btb_entry_t     f_ent, ex_ent, upd_ent;
   logic           f_hit, ex_hit, upd_en;

   assign f_idx  = pc_f[IDX+1:2];
   assign ex_idx = ex_pc[IDX+1:2];
   assign f_ent  = table_q[f_idx];
   assign ex_ent = table_q[ex_idx];
   assign f_hit  = f_ent.valid && (f_ent.tag == pc_f[WIDTH-1:IDX+2]);
   assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_pc[WIDTH-1:IDX+2]);

   // Fetch-side prediction and next-PC selection; a redirect overrides it.
   always_comb begin
      pred_taken_f  = f_hit && f_ent.ctr[CTR_BITS-1];
      pred_target_f = f_hit ? f_ent.target : pc_f + STEP;
      flush         = ex_valid && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_target != ex_pred_target)));
      if (flush) begin
         pc_next = ex_taken ? ex_target : ex_pc + STEP;
      end else if (pred_taken_f) begin
         pc_next = pred_target_f;
      end else begin
         pc_next = pc_f + STEP;
      end
   end

   // Training: build the new entry for the resolving branch's slot.
   always_comb begin
      upd_ent = ex_ent;
      upd_en  = 1'b0;
      if (ex_valid) begin
         if (ex_hit) begin
            upd_en = 1'b1;
            if (ex_taken) begin
               upd_ent.ctr    = CTR_BITS'(sat_inc(32'(ex_ent.ctr), CTR_MAX));
               upd_ent.target = ex_target;
            end else begin
               upd_ent.ctr = CTR_BITS'(sat_dec(32'(ex_ent.ctr)));
            end
         end else if (ex_taken) begin
            upd_en         = 1'b1;
            upd_ent.valid  = 1'b1;
            upd_ent.tag    = ex_pc[WIDTH-1:IDX+2];
            upd_ent.target = ex_target;
            upd_ent.ctr    = CTR_ALLOC;
         end
      end
   end

   // Table storage; lookup reads the pre-edge contents (no write bypass).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RST};
         end
      end else if (upd_en) begin
         table_q[ex_idx] <= upd_ent;
      end
   end

   bpu_sat_ctr #(
      .STAT_BITS (STAT_BITS)
   ) u_stat_branches (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (stat_clr),
      .inc_i  (ex_valid),
      .cnt_o  (stat_branches)
   );

   bpu_sat_ctr #(
      .STAT_BITS (STAT_BITS)
   ) u_stat_mispredicts (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (stat_clr),
      .inc_i  (flush),
      .cnt_o  (stat_mispredicts)
   );

endmodule

// File: tb/tb_bpu_btb.sv
// Bench for bpu_btb: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a behavioural BTB model.
module tb_bpu_btb;

   localparam int unsigned STAT_MAX = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_f, ex_pc, ex_target, ex_pred_target;
   logic        ex_valid, ex_taken, ex_pred_taken, stat_clr;
   logic [31:0] pc_next, pred_target_f;
   logic        pred_taken_f, flush;
   logic [3:0]  stat_branches, stat_mispredicts;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bpu_btb #(
      .WIDTH     (32),
      .ENTRIES   (16),
      .CTR_BITS  (2),
      .STAT_BITS (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .pc_f             (pc_f),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .ex_target        (ex_target),
      .ex_taken         (ex_taken),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .stat_clr         (stat_clr),
      .pc_next          (pc_next),
      .pred_taken_f     (pred_taken_f),
      .pred_target_f    (pred_target_f),
      .flush            (flush),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   // ---------------- behavioural model ----------------
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   int          m_br, m_mp;

   function automatic void mdl_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 1;
      end
      m_br = 0;
      m_mp = 0;
   endfunction

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   function automatic bit mdl_hit(input logic [31:0] pc);
      return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 64);
   endfunction

   function automatic bit mdl_pt(input logic [31:0] pc);
      return mdl_hit(pc) && (m_ctr[slot(pc)] >= 2);
   endfunction

   function automatic logic [31:0] mdl_ptgt(input logic [31:0] pc);
      return mdl_hit(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
   endfunction

   function automatic bit mdl_flush();
      if (!ex_valid) return 0;
      if (ex_taken != ex_pred_taken) return 1;
      return ex_taken && (ex_target != ex_pred_target);
   endfunction

   function automatic logic [31:0] mdl_next();
      if (mdl_flush()) return ex_taken ? ex_target : ex_pc + 32'd4;
      if (mdl_pt(pc_f)) return mdl_ptgt(pc_f);
      return pc_f + 32'd4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mdl_check();
      chk("pred_taken_f", 32'(pred_taken_f), 32'(mdl_pt(pc_f)));
      chk("pred_target_f", pred_target_f, mdl_ptgt(pc_f));
      chk("flush", 32'(flush), 32'(mdl_flush()));
      chk("pc_next", pc_next, mdl_next());
      chk("stat_branches", 32'(stat_branches), 32'(m_br));
      chk("stat_mispredicts", 32'(stat_mispredicts), 32'(m_mp));
   endtask

   // Drive one cycle's inputs mid-cycle.
   task automatic drive(input logic [31:0] pc, input bit v, input logic [31:0] epc,
                        input logic [31:0] etgt, input bit etk, input bit eptk,
                        input logic [31:0] eptgt, input bit clr);
      @(negedge clk);
      pc_f = pc; ex_valid = v; ex_pc = epc; ex_target = etgt; ex_taken = etk;
      ex_pred_taken = eptk; ex_pred_target = eptgt; stat_clr = clr;
      #1;
   endtask

   // Advance through the rising edge and apply the same edge to the model.
   task automatic commit();
      bit fl;
      int i;
      fl = mdl_flush();
      @(posedge clk);
      if (!rst) begin
         mdl_reset();
         return;
      end
      if (stat_clr) begin
         m_br = 0;
         m_mp = 0;
      end else begin
         if (ex_valid && m_br < STAT_MAX) m_br++;
         if (fl && m_mp < STAT_MAX) m_mp++;
      end
      if (ex_valid) begin
         i = slot(ex_pc);
         if (mdl_hit(ex_pc)) begin
            if (ex_taken) begin
               m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
               m_tgt[i] = ex_target;
            end else begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else if (ex_taken) begin
            m_valid[i] = 1;
            m_tag[i]   = ex_pc / 64;
            m_tgt[i]   = ex_target;
            m_ctr[i]   = 2;
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [31:0] pc;
      bit          v;
      logic [31:0] epc, etgt;
      bit          etk, eptk;
      logic [31:0] eptgt;
      bit          e_pt;
      logic [31:0] e_next;
      bit          e_fl;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] pc, input bit v, input logic [31:0] epc,
                               input logic [31:0] etgt, input bit etk, input bit eptk,
                               input logic [31:0] eptgt, input bit e_pt,
                               input logic [31:0] e_next, input bit e_fl);
      vec_t r;
      r.pc = pc; r.v = v; r.epc = epc; r.etgt = etgt; r.etk = etk; r.eptk = eptk;
      r.eptgt = eptgt; r.e_pt = e_pt; r.e_next = e_next; r.e_fl = e_fl;
      return r;
   endfunction

   vec_t vecs [14];

   initial begin
      rst = 1'b0;
      pc_f = 32'h100; ex_valid = 0; ex_pc = 0; ex_target = 0; ex_taken = 0;
      ex_pred_taken = 0; ex_pred_target = 0; stat_clr = 0;
      mdl_reset();

      // Outputs while held in reset.
      #2;
      chk("in_reset_pred_taken", 32'(pred_taken_f), 32'd0);
      chk("in_reset_pc_next", pc_next, 32'h104);
      @(negedge clk);
      rst = 1'b1;

      //           pc      v  ex_pc   ex_tgt  tk ptk ptgt     e_pt e_next   e_fl
      vecs[0]  = mk(32'h100, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 32'h104, 0);
      vecs[1]  = mk(32'h100, 1, 32'h100, 32'h200, 1, 0, 32'h0,   0, 32'h200, 1);
      vecs[2]  = mk(32'h100, 1, 32'h100, 32'h200, 1, 1, 32'h200, 1, 32'h200, 0);
      vecs[3]  = mk(32'h100, 1, 32'h100, 32'h200, 1, 1, 32'h200, 1, 32'h200, 0);
      vecs[4]  = mk(32'h100, 1, 32'h100, 32'h200, 1, 1, 32'h200, 1, 32'h200, 0);
      vecs[5]  = mk(32'h100, 1, 32'h100, 32'h200, 0, 1, 32'h200, 1, 32'h104, 1);
      vecs[6]  = mk(32'h100, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 32'h200, 0);
      vecs[7]  = mk(32'h100, 1, 32'h100, 32'h200, 0, 1, 32'h200, 1, 32'h104, 1);
      vecs[8]  = mk(32'h100, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 32'h104, 0);
      vecs[9]  = mk(32'h100, 1, 32'h140, 32'h500, 1, 0, 32'h0,   0, 32'h500, 1);
      vecs[10] = mk(32'h100, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 32'h104, 0);
      vecs[11] = mk(32'h140, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 32'h500, 0);
      vecs[12] = mk(32'h140, 1, 32'h140, 32'h300, 1, 1, 32'h500, 1, 32'h300, 1);
      vecs[13] = mk(32'h140, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 32'h300, 0);

      foreach (vecs[k]) begin
         drive(vecs[k].pc, vecs[k].v, vecs[k].epc, vecs[k].etgt, vecs[k].etk,
               vecs[k].eptk, vecs[k].eptgt, 0);
         chk($sformatf("vec%0d_pred_taken", k), 32'(pred_taken_f), 32'(vecs[k].e_pt));
         chk($sformatf("vec%0d_pc_next", k), pc_next, vecs[k].e_next);
         chk($sformatf("vec%0d_flush", k), 32'(flush), 32'(vecs[k].e_fl));
         mdl_check();
         commit();
      end
      drive(32'h140, 0, 0, 0, 0, 0, 0, 0);
      chk("dir_stat_branches", 32'(stat_branches), 32'd8);
      chk("dir_stat_mispredicts", 32'(stat_mispredicts), 32'd5);
      chk("dir_target_updated", pred_target_f, 32'h300);

      // Stat saturation, then clear racing an event.
      drive(32'h100, 0, 0, 0, 0, 0, 0, 1);
      commit();
      for (int n = 0; n < 16; n++) begin
         drive(32'h100, 1, 32'h3c0, 32'h0, 0, 0, 32'h0, 0);
         mdl_check();
         commit();
      end
      drive(32'h100, 0, 0, 0, 0, 0, 0, 0);
      chk("stat_saturated", 32'(stat_branches), 32'd15);
      drive(32'h100, 1, 32'h3c0, 32'h0, 0, 0, 32'h0, 1);
      commit();
      drive(32'h100, 0, 0, 0, 0, 0, 0, 0);
      chk("stat_clr_priority", 32'(stat_branches), 32'd0);
      commit();

      // Reset asserted while an allocating update is on the bus.
      drive(32'h140, 1, 32'h180, 32'h700, 1, 0, 32'h0, 0);
      rst = 1'b0;
      #1;
      chk("rst_pred_taken", 32'(pred_taken_f), 32'd0);
      chk("rst_pc_next_flush", pc_next, 32'h700);
      commit();
      drive(32'h180, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("post_rst_miss", 32'(pred_taken_f), 32'd0);
      chk("post_rst_pc_next", pc_next, 32'h184);
      chk("post_rst_stats", 32'(stat_branches), 32'd0);
      mdl_check();
      commit();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] pc, epc, etgt, eptgt;
         bit v, etk, eptk, clr;
         pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 40) == 0) pc = 32'hFFFF_FFFC;
         epc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 40) == 0) epc = 32'hFFFF_FFFC;
         etgt = $urandom_range(0, 7) << 4;
         v    = $urandom_range(0, 2) != 0;
         etk  = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 3) != 0) begin
            eptk  = mdl_pt(epc);
            eptgt = mdl_ptgt(epc);
         end else begin
            eptk  = $urandom_range(0, 1) != 0;
            eptgt = $urandom_range(0, 7) << 4;
         end
         clr = $urandom_range(0, 60) == 0;
         drive(pc, v, epc, etgt, etk, eptk, eptgt, clr);
         mdl_check();
         commit();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
